data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised, multi-cycle successor to the single-cycle data memory.
//  - Byte-addressed RV32 loads/stores: LB/LH/LW/LBU/LHU/SB/SH/SW, with byte-lane writes and sign/zero extension.
//  - Configurable wait states; valid/ready handshakes on both request and response.
//  - Sits between the core's execute/mem stage (ALU result = address, RS2 = store data) and writeback.
// PARAMETERS
//  XLEN     32   data and address width
//  DEPTH    256  number of XLEN-bit words in the array (power of two)
//  LATENCY  1    wait cycles between request accept and response (0..7)
// PORTS
//  clk         in   1     clock, all logic on posedge
//  reset       in   1     synchronous, active-low reset
//  req_valid   in   1     request present
//  req_ready   out  1     controller can accept a request
//  req_we      in   1     1 = store, 0 = load
//  req_funct3  in   3     RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr    in   XLEN  byte address
//  req_wdata   in   XLEN  store data, right-aligned (lane 0 = bits 7:0)
//  rsp_valid   out  1     response present
//  rsp_ready   in   1     consumer accepts response
//  rsp_rdata   out  XLEN  load result, extended; 0 for stores and errors
//  rsp_err     out  1     misaligned, out-of-range or illegal funct3
//  busy        out  1     FSM not in IDLE
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//    - FSM -> IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0.
//    - All array words cleared to 0.
//  FSM states and transitions:
//    - IDLE: req_ready=1. On req_valid&req_ready, latch we/funct3/addr/wdata; go to WAIT, or to RESP if LATENCY==0.
//    - WAIT: count down LATENCY-1..0; at count 0 -> RESP.
//    - RESP: rsp_valid=1, outputs held stable until rsp_valid&rsp_ready; then -> IDLE.
//  Request pacing:
//    - req_ready=0 outside IDLE; a request offered in RESP waits.
//    - Minimum spacing between accepts: LATENCY+2 cycles.
//  Store commit:
//    - The array write happens on the clock edge that enters RESP.
//    - Only enabled lanes are written: B -> 1 lane at addr[1:0]; H -> lanes addr[1]*2 +{0,1}; W -> all 4.
//  Load read:
//    - The word is sampled on the same edge that enters RESP, then lane-selected and extended.
//    - B/H are sign-extended; BU/HU are zero-extended.
//  Word index and range:
//    - Word index = addr[$clog2(DEPTH)+1:2].
//    - Out of range if addr >= DEPTH*4.
//  Error conditions:
//    - H/HU with addr[0]=1.
//    - W with addr[1:0]!=0.
//    - funct3 not listed above, or stores with funct3 100/101.
//    - Out of range.
//  Error response:
//    - rsp_err=1, rsp_rdata=0.
//    - No array write; the FSM still runs its full latency.
//  Store responses are returned as normal responses, with rsp_rdata=0.
//  Reset mid-operation:
//    - The transaction is abandoned and no response is produced.
//    - A store not yet committed is dropped.
//  Read-after-write: a load accepted after a store's response sees the stored data.
// STRUCTURE
//  Shared package: funct3 encodings (F3_B/H/W/BU/HU), FSM state encoding (IDLE/WAIT/RESP).
//  Sub-module mem_lane_align (combinational):
//    - addr[1:0] + funct3 -> byte-enable mask, shifted write data, extended read data, misalign flag.
//  Top level holds the FSM, latency counter, request latches and word array.
// TESTING
//  1 LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid 2 cycles after accept, rdata=0xDEADBEEF, err=0.
//  2 SB 0x80 @0x11, then LB @0x11 -> 0xFFFFFF80; LBU @0x11 -> 0x00000080; LW @0x10 -> 0xDEAD80EF.
//  3 SH 0x1234 @0x12, LHU @0x12 -> 0x00001234; LH @0x13 -> err=1, rdata=0; word @0x10 unchanged.
//  4 LW @DEPTH*4 -> err=1; SW @0x3 -> err=1 and a following LW @0x0 returns 0.
//  5 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0; a new req_valid is accepted only after the handshake.
//  6 Drive reset=0 in WAIT of SW @0x20 -> no response; after release, LW @0x20 -> 0; LATENCY=0 build: response 1 cycle after accept.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the data memory controller: RV32 load/store funct3 values and FSM states.
package data_mem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_ctrl_mem_lane_align.sv
// Combinational lane steering for 32-bit words: byte enables, write-data replication,
// read extraction with sign/zero extension, plus misalign/illegal-funct3 flags.
module mem_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_aligned,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [15:0] shifted;

    always_comb begin
        byte_en       = 4'b0000;
        wdata_aligned = '0;
        rdata_ext     = '0;
        misalign      = 1'b0;
        illegal       = 1'b0;
        shifted       = 16'(rword >> {addr_lo, 3'b000});

        // Store data is replicated across lanes; byte_en picks the lanes that land.
        case (funct3)
            F3_B: begin
                byte_en       = 4'b0001 << addr_lo;
                wdata_aligned = {4{wdata[7:0]}};
                rdata_ext     = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                illegal   = we;
                rdata_ext = {24'd0, shifted[7:0]};
            end
            F3_H: begin
                misalign      = addr_lo[0];
                byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_aligned = {2{wdata[15:0]}};
                rdata_ext     = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                misalign  = addr_lo[0];
                illegal   = we;
                rdata_ext = {16'd0, shifted[15:0]};
            end
            F3_W: begin
                misalign      = |addr_lo;
                byte_en       = 4'b1111;
                wdata_aligned = wdata;
                rdata_ext     = rword;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle RV32 data memory: one request in flight, response LATENCY+1 cycles after accept.
// req_ready only in IDLE; the response is held in RESP until rsp_ready.
module data_mem_ctrl #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            busy
);
    import data_mem_ctrl_pkg::*;

    localparam int AW = $clog2(DEPTH);

    state_t          state, state_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic            enter_resp;

    logic            we_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic [XLEN-1:0] mem [DEPTH];

    logic            cur_we;
    logic [2:0]      cur_f3;
    logic [XLEN-1:0] cur_addr, cur_wdata;
    logic [AW-1:0]   word_idx;
    logic            out_of_range;
    logic [XLEN-1:0] rword;
    logic [3:0]      byte_en;
    logic [XLEN-1:0] wdata_aligned, rdata_ext;
    logic            misalign, illegal, err;
    logic            accept;

    assign accept = req_valid && (state == IDLE);

    // With LATENCY==0 the commit edge is the accept edge, so the live request is used directly.
    assign cur_we    = (state == IDLE) ? req_we     : we_q;
    assign cur_f3    = (state == IDLE) ? req_funct3 : f3_q;
    assign cur_addr  = (state == IDLE) ? req_addr   : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata  : wdata_q;

    assign word_idx     = cur_addr[AW+1:2];
    assign out_of_range = |cur_addr[XLEN-1:AW+2];
    assign rword        = mem[word_idx];
    assign err          = misalign | illegal | out_of_range;

    mem_lane_align u_align (
        .addr_lo       (cur_addr[1:0]),
        .funct3        (cur_f3),
        .we            (cur_we),
        .wdata         (cur_wdata),
        .rword         (rword),
        .byte_en       (byte_en),
        .wdata_aligned (wdata_aligned),
        .rdata_ext     (rdata_ext),
        .misalign      (misalign),
        .illegal       (illegal)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 3'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= (err || cur_we) ? '0 : rdata_ext;
                err_q   <= err;
            end else if (state == RESP && rsp_ready) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enter_resp && cur_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][b*8 +: 8] <= wdata_aligned[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl (LATENCY=1 main instance, LATENCY=0 secondary instance).
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        r0_req_valid, r0_req_ready, r0_req_we;
    logic [2:0]  r0_req_funct3;
    logic [31:0] r0_req_addr, r0_req_wdata;
    logic        r0_rsp_valid, r0_rsp_err, r0_busy;
    logic [31:0] r0_rsp_rdata;

    data_mem_ctrl u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    data_mem_ctrl #(.LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(r0_req_valid), .req_ready(r0_req_ready), .req_we(r0_req_we),
        .req_funct3(r0_req_funct3), .req_addr(r0_req_addr), .req_wdata(r0_req_wdata),
        .rsp_valid(r0_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(r0_rsp_rdata),
        .rsp_err(r0_rsp_err), .busy(r0_busy)
    );

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input bit expect_rsp, output int acc);
        int waited = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        if (expect_rsp) sb.push_back('{exp_rdata, exp_err, cyc});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    endtask

    // Monitor: pops on each handshake; latency measured from first cycle rsp_valid is seen.
    initial begin
        bit   seen = 1'b0;
        int   first = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                seen = 1'b0;
            end else if (rsp_valid) begin
                if (!seen) begin
                    seen  = 1'b1;
                    first = cyc;
                end
                if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        check("rsp_latency", first - e.acc, 32'd2);
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int acc, acc2, hs;
        reset = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        r0_req_valid = 1'b0; r0_req_we = 1'b0; r0_req_funct3 = 3'd0; r0_req_addr = '0; r0_req_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        send(1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, acc);
        send(1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, acc);

        send(1'b1, F3_B,  32'h11, 32'h80,       32'h0,        1'b0, 1'b1, acc);
        send(1'b0, F3_B,  32'h11, 32'h0,        32'hFFFFFF80, 1'b0, 1'b1, acc);
        send(1'b0, F3_BU, 32'h11, 32'h0,        32'h00000080, 1'b0, 1'b1, acc);
        send(1'b0, F3_W,  32'h10, 32'h0,        32'hDEAD80EF, 1'b0, 1'b1, acc);

        send(1'b1, F3_H,  32'h12, 32'h1234,     32'h0,        1'b0, 1'b1, acc);
        send(1'b0, F3_HU, 32'h12, 32'h0,        32'h00001234, 1'b0, 1'b1, acc);
        send(1'b0, F3_H,  32'h13, 32'h0,        32'h0,        1'b1, 1'b1, acc);
        send(1'b0, F3_W,  32'h10, 32'h0,        32'h123480EF, 1'b0, 1'b1, acc);
        send(1'b0, F3_H,  32'h10, 32'h0,        32'hFFFF80EF, 1'b0, 1'b1, acc);
        send(1'b0, F3_B,  32'h13, 32'h0,        32'h00000012, 1'b0, 1'b1, acc);

        send(1'b0, F3_W,  32'h400, 32'h0,       32'h0,        1'b1, 1'b1, acc);
        send(1'b1, F3_W,  32'h3,  32'h11223344, 32'h0,        1'b1, 1'b1, acc);
        send(1'b0, F3_W,  32'h0,  32'h0,        32'h0,        1'b0, 1'b1, acc);
        send(1'b1, F3_BU, 32'h10, 32'hFF,       32'h0,        1'b1, 1'b1, acc);
        send(1'b0, 3'b011, 32'h10, 32'h0,       32'h0,        1'b1, 1'b1, acc);
        send(1'b0, F3_W,  32'h10, 32'h0,        32'h123480EF, 1'b0, 1'b1, acc);

        // Backpressure: hold the response, offer a second request meanwhile.
        drain();
        rsp_ready = 1'b0;
        send(1'b0, F3_W, 32'h10, 32'h0, 32'h123480EF, 1'b0, 1'b1, acc);
        hs = 0;
        fork
            send(1'b0, F3_BU, 32'h12, 32'h0, 32'h00000034, 1'b0, 1'b1, acc2);
            begin
                for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                    check("hold_rsp_rdata", rsp_rdata, 32'h123480EF);
                    check("hold_req_ready", {31'd0, req_ready}, 32'd0);
                    @(negedge clk);
                end
                hs = cyc;
                rsp_ready = 1'b1;
            end
        join
        check("accept_after_handshake", acc2, hs + 1);

        // Reset during WAIT of a store: no response, store dropped.
        drain();
        send(1'b1, F3_W, 32'h20, 32'hAAAA5555, 32'h0, 1'b0, 1'b0, acc);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(1'b0, F3_W, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        send(1'b0, F3_W, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, acc);

        // LATENCY=0 instance: response visible one cycle after accept.
        r0_req_valid = 1'b1; r0_req_we = 1'b1; r0_req_funct3 = F3_W;
        r0_req_addr = 32'h8; r0_req_wdata = 32'h55AA1234;
        check("l0_req_ready", {31'd0, r0_req_ready}, 32'd1);
        @(negedge clk);
        r0_req_valid = 1'b0;
        check("l0_store_rsp_valid", {31'd0, r0_rsp_valid}, 32'd1);
        check("l0_store_rsp_rdata", r0_rsp_rdata, 32'd0);
        @(negedge clk);
        check("l0_idle_busy", {31'd0, r0_busy}, 32'd0);
        r0_req_valid = 1'b1; r0_req_we = 1'b0; r0_req_funct3 = F3_H; r0_req_addr = 32'hA;
        @(negedge clk);
        r0_req_valid = 1'b0;
        check("l0_load_rsp_valid", {31'd0, r0_rsp_valid}, 32'd1);
        check("l0_load_rsp_rdata", r0_rsp_rdata, 32'h000055AA);
        check("l0_load_rsp_err", {31'd0, r0_rsp_err}, 32'd0);

        drain();
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
